// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_LSL  = 4'b0011,
    OP_LSR  = 4'b0100,
    OP_ROL  = 4'b0101,
    OP_ROR  = 4'b0110,
    OP_AND  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_NOT  = 4'b1010,
    OP_CLR  = 4'b1011,
    OP_LSLO = 4'b1100,
    OP_ASR  = 4'b1101,
    OP_MULL = 4'b1110,
    OP_MULH = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL,
    DONE
  } state_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_shift_op(alu_op_t op);
    return op inside {OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_LSLO, OP_ASR};
  endfunction

  function automatic logic is_mul_op(alu_op_t op);
    return op inside {OP_MULL, OP_MULH};
  endfunction

  function automatic logic [3:0] pack_flags(logic c, logic n, logic z, logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one shift/rotate position or one multiplier bit per cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  alu_op_t          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  // Upper half collects LSLO overflow bits or the running MUL partial product;
  // lower half is the shifted operand or the remaining multiplier bits.
  logic [2*WIDTH-1:0] r_work;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_cnt;
  alu_op_t            r_op;

  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_psum;
  logic [2*WIDTH-1:0] w_next;
  logic               w_cout;

  always_comb begin
    w_lo     = r_work[WIDTH-1:0];
    w_hi     = r_work[2*WIDTH-1:WIDTH];
    w_addend = w_lo[0] ? r_mcand : '0;
    w_psum   = {1'b0, w_hi} + {1'b0, w_addend};
    w_next   = r_work;
    w_cout   = 1'b0;
    case (r_op)
      OP_LSL, OP_LSLO: begin
        w_next = r_work << 1;
        w_cout = w_lo[WIDTH-1];
      end
      OP_LSR: begin
        w_next = {w_hi, 1'b0, w_lo[WIDTH-1:1]};
        w_cout = w_lo[0];
      end
      OP_ASR: begin
        w_next = {w_hi, w_lo[WIDTH-1], w_lo[WIDTH-1:1]};
        w_cout = w_lo[0];
      end
      OP_ROL:           w_next = {w_hi, w_lo[WIDTH-2:0], w_lo[WIDTH-1]};
      OP_ROR:           w_next = {w_hi, w_lo[0], w_lo[WIDTH-1:1]};
      OP_MULL, OP_MULH: w_next = {w_psum, w_lo[WIDTH-1:1]};
      default:          w_next = r_work;
    endcase
  end

  // Result and carry describe the state after the step taken this cycle,
  // so the top can capture them on the same edge that finishes the op.
  always_comb begin
    o_done   = (r_cnt == CW'(1));
    o_result = w_next[WIDTH-1:0];
    o_carry  = 1'b0;
    case (r_op)
      OP_LSLO, OP_MULH:       o_result = w_next[2*WIDTH-1:WIDTH];
      default:                o_result = w_next[WIDTH-1:0];
    endcase
    case (r_op)
      OP_LSL, OP_LSR, OP_ASR: o_carry = w_cout;
      OP_MULL:                o_carry = |w_next[2*WIDTH-1:WIDTH];
      default:                o_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_op    <= OP_PASS;
    end else if (i_start) begin
      r_op <= i_op;
      if (is_mul_op(i_op)) begin
        r_work  <= {{WIDTH{1'b0}}, i_b};
        r_mcand <= i_a;
        r_cnt   <= CW'(WIDTH);
      end else begin
        r_work  <= {{WIDTH{1'b0}}, i_a};
        r_mcand <= '0;
        r_cnt   <= CW'(i_b[SHW-1:0]);
      end
    end else if (r_cnt != '0) begin
      r_work <= w_next;
      r_cnt  <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: operand handshake, single-cycle ops, FSM and flag generation.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             cin,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W1  = WIDTH + 1;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic [3:0]       r_flags;

  alu_op_t          w_op;
  logic [SHW-1:0]   w_k;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_is_mul;
  logic             w_iter;
  logic             w_accept;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_res;
  logic             w_iter_carry;

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign flags     = r_flags;

  always_comb begin
    w_op  = alu_op_t'(alu_op);
    w_k   = input_B[SHW-1:0];
    w_add = {1'b0, input_A} + {1'b0, input_B} + W1'(cin);
    w_sub = {1'b0, input_A} + {1'b0, ~input_B} + W1'(1);
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_PASS: w_res = input_A;
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (input_A[WIDTH-1] == input_B[WIDTH-1]) &&
                (w_add[WIDTH-1] != input_A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (input_A[WIDTH-1] != input_B[WIDTH-1]) &&
                (w_sub[WIDTH-1] != input_A[WIDTH-1]);
      end
      // Only reached here with k=0: shifts and rotates pass A, LSLO yields 0.
      OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_ASR: w_res = input_A;
      OP_AND:  w_res = input_A & input_B;
      OP_OR:   w_res = input_A | input_B;
      OP_XOR:  w_res = input_A ^ input_B;
      OP_NOT:  w_res = ~input_A;
      default: w_res = '0;
    endcase
    w_is_mul = is_mul_op(w_op);
    w_iter   = w_is_mul || (is_shift_op(w_op) && (w_k != '0));
    w_accept = in_valid && in_ready;
  end

  alu_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept && w_iter),
    .i_op     (w_op),
    .i_a      (input_A),
    .i_b      (input_B),
    .o_done   (w_iter_done),
    .o_result (w_iter_res),
    .o_carry  (w_iter_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_iter) begin
              r_state <= w_is_mul ? MUL : SHIFT;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_out       <= w_res;
              r_flags     <= pack_flags(w_c, w_res[WIDTH-1], ~|w_res, w_v);
            end
          end
        end
        SHIFT, MUL: begin
          if (w_iter_done) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out       <= w_iter_res;
            r_flags     <= pack_flags(w_iter_carry, w_iter_res[WIDTH-1],
                                      ~|w_iter_res, 1'b0);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table plus hold and reset sequences.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_op;
  logic       cin;
  logic [7:0] input_A;
  logic [7:0] input_B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dut_out;
  logic [3:0] flags;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .cin       (cin),
    .input_A   (input_A),
    .input_B   (input_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out),
    .flags     (flags)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_out;
    logic [3:0] exp_flags;  // {C,N,Z,V}
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns at the negedge after the acceptance edge.
  task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    alu_op   = op;
    input_A  = a;
    input_B  = b;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start_op(v.op, v.a, v.b, v.c);
    wait_valid(lat);
    check($sformatf("v%0d_out", idx), 32'(dut_out), 32'(v.exp_out));
    check($sformatf("v%0d_flags", idx), 32'(flags), 32'(v.exp_flags));
    check($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.exp_lat));
    finish_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int stale;

    //            op      a      b      cin  out    CNZV     L
    vecs.push_back('{4'h1, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010, 1});
    vecs.push_back('{4'h2, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1001, 1});
    vecs.push_back('{4'h2, 8'h05, 8'h07, 1'b0, 8'hFE, 4'b0100, 1});
    vecs.push_back('{4'h6, 8'h81, 8'h03, 1'b0, 8'h30, 4'b0000, 4});
    vecs.push_back('{4'h6, 8'h81, 8'h0B, 1'b0, 8'h30, 4'b0000, 4});
    vecs.push_back('{4'hC, 8'hB4, 8'h03, 1'b0, 8'h05, 4'b0000, 4});
    vecs.push_back('{4'hE, 8'hFF, 8'hFF, 1'b0, 8'h01, 4'b1000, 9});
    vecs.push_back('{4'hF, 8'hFF, 8'hFF, 1'b0, 8'hFE, 4'b0100, 9});
    vecs.push_back('{4'h1, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, 1});
    vecs.push_back('{4'h1, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000, 1});
    vecs.push_back('{4'h3, 8'h81, 8'h01, 1'b0, 8'h02, 4'b1000, 2});
    vecs.push_back('{4'h4, 8'h81, 8'h01, 1'b0, 8'h40, 4'b1000, 2});
    vecs.push_back('{4'hD, 8'h80, 8'h07, 1'b0, 8'hFF, 4'b0100, 8});
    vecs.push_back('{4'h4, 8'h80, 8'h07, 1'b0, 8'h01, 4'b0000, 8});
    vecs.push_back('{4'h3, 8'h01, 8'h00, 1'b0, 8'h01, 4'b0000, 1});
    vecs.push_back('{4'hC, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b0010, 1});
    vecs.push_back('{4'h5, 8'h81, 8'h04, 1'b0, 8'h18, 4'b0000, 5});
    vecs.push_back('{4'h7, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 1});
    vecs.push_back('{4'h8, 8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b0100, 1});
    vecs.push_back('{4'h9, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0010, 1});
    vecs.push_back('{4'hA, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0100, 1});
    vecs.push_back('{4'hB, 8'h5A, 8'hA5, 1'b1, 8'h00, 4'b0010, 1});
    vecs.push_back('{4'h0, 8'h80, 8'h33, 1'b1, 8'h80, 4'b0100, 1});
    vecs.push_back('{4'h2, 8'h07, 8'h07, 1'b0, 8'h00, 4'b1010, 1});
    vecs.push_back('{4'h2, 8'h7F, 8'hFF, 1'b0, 8'h80, 4'b0101, 1});
    vecs.push_back('{4'hE, 8'h0F, 8'h11, 1'b0, 8'hFF, 4'b0100, 9});
    vecs.push_back('{4'hF, 8'h0F, 8'h11, 1'b0, 8'h00, 4'b0010, 9});

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; cin = 1'b0; input_A = '0; input_B = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(dut_out), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-pressure: result must hold while inputs wiggle, nothing accepted.
    start_op(4'h1, 8'hFF, 8'h01, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      alu_op   = 4'($urandom);
      input_A  = 8'($urandom);
      input_B  = 8'($urandom);
      cin      = 1'($urandom);
      @(negedge clk);
      check("hold_out", 32'(dut_out), 32'h00);
      check("hold_flags", 32'(flags), 32'b1010);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end

    // out_ready and in_valid together in DONE: operand taken one cycle later.
    alu_op = 4'h0; input_A = 8'h55; input_B = 8'h00; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("dual_out_valid", 32'(out_valid), 32'd0);
    check("dual_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("dual_next_valid", 32'(out_valid), 32'd1);
    check("dual_next_out", 32'(dut_out), 32'h55);
    check("dual_next_flags", 32'(flags), 32'b0000);
    finish_result();

    // Reset in the 4th MUL cycle aborts the multiply.
    start_op(4'hE, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_out", 32'(dut_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_ready_after", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    check("mrst_no_stale", 32'(stale), 32'd0);
    run_vec(vecs[9], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
    $finish;
  end

endmodule
